// File: rtl/mm_ctrl_pkg.sv
// Shared types and constants for the matrix-multiply control slice.
// Holds the output write scheduler state encoding and its default tile limit.
package mm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_CPL = 2'd2,
    REPORT   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_MAX_TILES = 16;

endpackage

// File: rtl/output_write_scheduler.sv
// Issues one write instruction per output tile and reports job completion.
// Optional OUTPUT_WRITE_SCHED_PERF_EN adds a saturating busy-cycle counter.
module output_write_scheduler
  import mm_ctrl_pkg::*;
#(
  parameter int N                   = 4,
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int MAX_TILES           = DEFAULT_MAX_TILES,
  parameter int TILE_COUNT_BITS     = $clog2(MAX_TILES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0] job_base_address,
  input  logic [MEMORY_ADDRESS_BITS-1:0] job_tile_stride,
  input  logic [TILE_COUNT_BITS-1:0]     job_tile_count,
  input  logic                           job_by_row,

  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0] instr_address,
  output logic                           instr_by_row,

  input  logic                           completed_valid,
  output logic                           completed_ready,

  output logic                           done_valid,
  input  logic                           done_ready,

  output logic                           busy,
  output logic [TILE_COUNT_BITS-1:0]     tiles_done,
  output logic                           error_flag
`ifdef OUTPUT_WRITE_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_busy_cycles
`endif
);

  if (N < 1 || MAX_TILES < 1) begin : g_bad_params
    $error("output_write_scheduler: N and MAX_TILES must be positive");
  end

  sched_state_t state_q, state_d;

  logic [MEMORY_ADDRESS_BITS-1:0] cur_addr_q;
  logic [MEMORY_ADDRESS_BITS-1:0] stride_q;
  logic [TILE_COUNT_BITS-1:0]     tile_count_q;
  logic [TILE_COUNT_BITS-1:0]     tiles_done_q;
  logic [TILE_COUNT_BITS-1:0]     tiles_done_inc;
  logic                           by_row_q;
  logic                           error_q;

  logic job_fire;
  logic instr_fire;
  logic cpl_fire;
  logic done_fire;
  logic job_empty;
  logic job_oversize;

  assign job_fire     = job_valid && job_ready;
  assign instr_fire   = instr_valid && instr_ready;
  assign cpl_fire     = completed_valid && completed_ready;
  assign done_fire    = done_valid && done_ready;
  assign job_empty    = (job_tile_count == '0);
  assign job_oversize = (int'(job_tile_count) > MAX_TILES);

  assign tiles_done_inc = tiles_done_q + TILE_COUNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    job_ready       = 1'b0;
    instr_valid     = 1'b0;
    completed_ready = 1'b0;
    done_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_fire) begin
          if (job_empty || job_oversize) begin
            state_d = REPORT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_fire) begin
          state_d = WAIT_CPL;
        end
      end
      WAIT_CPL: begin
        completed_ready = 1'b1;
        if (cpl_fire) begin
          if (tiles_done_inc == tile_count_q) begin
            state_d = REPORT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      REPORT: begin
        done_valid = 1'b1;
        if (done_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An oversized job is latched but never issued; it only raises the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr_q   <= '0;
      stride_q     <= '0;
      tile_count_q <= '0;
      tiles_done_q <= '0;
      by_row_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (job_fire) begin
        cur_addr_q   <= job_base_address;
        stride_q     <= job_tile_stride;
        tile_count_q <= job_tile_count;
        tiles_done_q <= '0;
        by_row_q     <= job_by_row;
        error_q      <= job_oversize;
      end
      if (cpl_fire) begin
        tiles_done_q <= tiles_done_inc;
        cur_addr_q   <= cur_addr_q + stride_q;
      end
    end
  end

  assign instr_address = cur_addr_q;
  assign instr_by_row  = by_row_q;
  assign busy          = (state_q != IDLE);
  assign tiles_done    = tiles_done_q;
  assign error_flag    = error_q;

`ifdef OUTPUT_WRITE_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: doc/output_write_scheduler.md
OUTPUT_WRITE_SCHEDULER -- requirements
Module: output_write_scheduler

Interface
REQ-001 SHALL have parameter N, default 4, processing array width (elements per output tile row/col).
REQ-002 SHALL have parameter MEMORY_ADDRESS_BITS, default 64, memory address width.
REQ-003 SHALL have parameter MAX_TILES, default 16, max tiles per job; TILE_COUNT_BITS = $clog2(MAX_TILES+1).
REQ-004 SHALL have port clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have job_valid input 1, job_ready output 1: job handshake from controller.
REQ-006 SHALL have job_base_address input MEMORY_ADDRESS_BITS, job_tile_stride input MEMORY_ADDRESS_BITS, job_tile_count input TILE_COUNT_BITS, job_by_row input 1.
REQ-007 SHALL have instr_valid output 1, instr_ready input 1, instr_address output MEMORY_ADDRESS_BITS, instr_by_row output 1: per-tile instruction to the output memory writer.
REQ-008 SHALL have completed_valid input 1, completed_ready output 1: per-tile write-done handshake from the writer.
REQ-009 SHALL have done_valid output 1, done_ready input 1: job-complete handshake to controller.
REQ-010 SHALL have busy output 1 (state != IDLE) and tiles_done output TILE_COUNT_BITS (tiles completed in current job).

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT_CPL, REPORT.
REQ-012 SHALL assert job_ready only in IDLE; on job_valid&&job_ready, SHALL latch all job fields, clear tiles_done, set cur_addr = job_base_address.
REQ-013 SHALL go IDLE->ISSUE on accept when job_tile_count>0; IDLE->REPORT when job_tile_count==0, or when job_tile_count>MAX_TILES (job dropped, error_flag set).
REQ-014 SHALL drive instr_valid=1 in ISSUE only, first asserted the cycle after job accept; instr_address=cur_addr, instr_by_row=latched job_by_row, both stable while instr_valid && !instr_ready.
REQ-015 SHALL go ISSUE->WAIT_CPL on instr_valid&&instr_ready; at most one tile outstanding.
REQ-016 SHALL assert completed_ready only in WAIT_CPL; completed_valid in other states SHALL be ignored and not counted.
REQ-017 SHALL on completed handshake increment tiles_done, set cur_addr = cur_addr + tile_stride (modulo 2^MEMORY_ADDRESS_BITS, wrap silent); next state REPORT if tiles_done+1 == tile_count else ISSUE.
REQ-018 SHALL assert done_valid only in REPORT; on done_valid&&done_ready return to IDLE, job_ready high next cycle.
REQ-019 SHALL expose error_flag (output 1) through the done phase; cleared on next job accept.

Reset
REQ-020 SHALL on reset (any state, incl. mid-tile) force IDLE, job_ready=1 after reset deasserts, instr_valid=0, completed_ready=0, done_valid=0, busy=0, tiles_done=0, error_flag=0, internal address/count registers 0.

Configuration
REQ-021 SHALL, with OUTPUT_WRITE_SCHED_PERF_EN defined, add output perf_busy_cycles (32 bit): increments every cycle busy=1, saturates at 2^32-1, cleared by reset only.
REQ-022 SHALL, without OUTPUT_WRITE_SCHED_PERF_EN, omit the port and counter entirely; all other behaviour identical.

Structure
REQ-023 SHALL place the FSM state enum (sched_state_t) and the default MAX_TILES constant in shared package mm_ctrl_pkg.
REQ-024 SHALL be a single module with no sub-modules; the writer is instantiated alongside it by the integration level.

Verification
REQ-025 Job base=0x100, stride=4, count=3, by_row=1, writer always ready, completion 5 cycles after each instr -> instr_address 0x100,0x104,0x108 in order, one done_valid, tiles_done=3.
REQ-026 count=0 -> no instr_valid, done_valid one cycle after accept, error_flag=0; count=MAX_TILES+1 -> no instr_valid, done_valid, error_flag=1.
REQ-027 instr_ready held low 10 cycles -> instr_valid, instr_address stable throughout; completed_valid pulsed during ISSUE -> ignored, tiles_done unchanged.
REQ-028 base=2^64-4, stride=4, count=2 -> second instr_address=0x0.
REQ-029 reset asserted in WAIT_CPL of tile 2 -> next cycle IDLE, all outputs at reset values; new job then runs normally from tile 0.
REQ-030 done_ready low 7 cycles, job_valid high -> done_valid held, job_ready 0 until done handshake; PERF_EN build: perf_busy_cycles equals busy cycle count.
